cordic_vec_collect: RTL and testbench
=====================================

# cordic_vec_collect

Result collector downstream of the 16-iteration CORDIC vectoring core. It tracks samples issued into the non-stallable core with a valid/tag delay line matched to the core latency, and applies left-half-plane angle correction to each result. Corrected magnitude/angle pairs are buffered in a FIFO with a ready/valid output. Upstream issue is gated by credits, so a result is never dropped when the consumer stalls.

## Interface
- N, 31, MSB index of core x/y data (data width N+1, signed)
- M, 31, MSB index of core angle (width M+1, two's complement degrees, 12 integer / 20 fractional bits)
- LAT, 17, core latency in cycles from x0/y0 sample to xf/yf/output_angle valid
- DEPTH, 32, FIFO entries; power of two, must be ≥ LAT+1

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- issue_valid  in  1  upstream presents a sample to the core this cycle
- issue_x_neg  in  1  original x was negative (core is fed |x|)
- issue_ready  out  1  credit available; sample enters core only when issue_valid & issue_ready
- core_xf  in  N+1  core magnitude output
- core_angle  in  M+1  core angle output
- m_valid  out  1  FIFO head valid
- m_ready  in  1  consumer accepts head
- m_mag  out  N+1  head magnitude
- m_angle  out  M+1  head corrected angle

## Operation
- Issue: an accepted sample pushes {1, x_neg} into a LAT-deep delay line; otherwise {0, 0} is pushed. The delay line shifts every cycle.
- Arrival: when delay-line tap LAT is valid, the block captures core_xf and core_angle (θ') into the correction register, with its valid bit and tag.
- Correction, registered:
  - x_neg=0: angle = θ'.
  - x_neg=1, θ'≥0: angle = 180° − θ'.
  - x_neg=1, θ'<0: angle = −180° − θ'.
  - 180° = 32'h0B4_00000. Arithmetic is M+1-bit two's complement; no saturation is needed because the result range is [−180°, +180°].
- Magnitude passes through unchanged.
- Push: a valid correction register writes {mag, angle} to the FIFO on the next edge.
- Pop: the FIFO pops when m_valid & m_ready. m_mag/m_angle show the head combinationally from storage; they hold their value while m_valid=0.
- Credit: occ = inflight + fifo_count. inflight counts valid bits in the delay line plus the correction register.
  - issue_ready = (occ < DEPTH).
  - inflight increments on accept and decrements on push. Simultaneous accept and push leaves inflight unchanged.
- Boundaries:
  - A push into a full FIFO cannot occur by construction. An assertion fires if it does.
  - A pop on an empty FIFO is a no-op.
  - Simultaneous push and pop at any fill level keeps the count constant.
  - Pointers wrap modulo DEPTH.
  - θ' = 0 with x_neg=1 gives exactly +180°.
  - A zero input (core outputs 0/0) with x_neg=0 is stored as 0/0.
- Reset asserted, including mid-operation:
  - delay line, correction register, inflight, FIFO pointers and count clear to 0.
  - m_valid = 0, m_mag = 0, m_angle = 0, issue_ready = 1 once rst deasserts.
  - In-flight core results are discarded.

## Timing
- Sample accepted at edge t. The core result is captured at edge t+LAT, pushed at edge t+LAT+1, and m_valid rises in cycle t+LAT+1 after that edge. Issue-to-output latency is LAT+1 edges.
- Throughput is one sample per cycle sustained while m_ready stays high.
- issue_ready is combinational from registered counters only; it has no path from issue_valid.
- With m_ready held low, exactly DEPTH samples are accepted and then issue_ready deasserts. Each pop re-enables one credit in the following cycle.

## Structure
- Package cordic_pkg holds:
  - ANG_180 = 32'h0B4_00000 and the ANG_M180 constant.
  - Default LAT=17, the shared N/M defaults, and the result struct type {mag, angle}.
- Sub-module cordic_res_fifo: synchronous FIFO, DEPTH×(N+M+2) bits, with push/pop/full/empty/count. Async active-low reset on pointers and count only.
- The delay line, credit counter and correction logic live in the top.

## Test plan
- Single sample: x_neg=0, core_angle=32'h035_22000 at arrival, m_ready=1 → m_valid 1 cycle high at t+LAT+1 with m_angle=32'h035_22000.
- Mirror correction on x_neg=1:
  - θ'=32'h035_22000 → m_angle = 32'h0B4_00000 − 32'h035_22000.
  - θ'=−32'h02D_00000 → m_angle = −32'h087_00000.
  - θ'=0 → 32'h0B4_00000.
- Backpressure: m_ready=0 with continuous issue_valid → exactly 32 accepts, then issue_ready=0. Release m_ready → 32 results in order, none lost or duplicated.
- Full-rate stream of 100 samples with m_ready=1 and a random x_neg pattern → outputs in issue order, one per cycle, each tag correctly applied.
- Mid-stream reset with 10 in flight and 5 in the FIFO → m_valid=0 and outputs 0 immediately; issue_ready=1 after release. No stale result appears within the next LAT+2 cycles.
- Random m_ready toggling at 50% combined with simultaneous push/pop at FIFO fill 0, DEPTH−1 and DEPTH → count is correct and no overflow assertion fires.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared defaults, angle constants and result payload for the CORDIC vectoring collector.
package cordic_pkg;

  localparam int unsigned N_DEF     = 31;
  localparam int unsigned M_DEF     = 31;
  localparam int unsigned LAT_DEF   = 17;
  localparam int unsigned DEPTH_DEF = 32;

  // Degrees in 12.20 two's complement
  localparam logic [31:0] ANG_180  = 32'h0B40_0000;
  localparam logic [31:0] ANG_M180 = 32'hF4C0_0000;

  typedef struct packed {
    logic [N_DEF:0] mag;
    logic [M_DEF:0] angle;
  } cordic_res_t;

endpackage

// File: rtl/cordic_res_fifo.sv
// Synchronous result FIFO; storage is not reset, only pointers and count.
module cordic_res_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop_c;

  assign do_pop_c = pop & ~empty;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign rdata    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + AW'(1);
      if (do_pop_c) rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop_c})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  ast_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: rtl/cordic_vec_collect.sv
// Tracks samples through the fixed-latency CORDIC core, fixes left-half-plane angles
// and buffers results behind a credit-gated ready/valid interface.
module cordic_vec_collect
  import cordic_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned M     = M_DEF,
  parameter int unsigned LAT   = LAT_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic       issue_x_neg,
  output logic       issue_ready,
  input  logic [N:0] core_xf,
  input  logic [M:0] core_angle,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [N:0] m_mag,
  output logic [M:0] m_angle
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned W  = N + M + 2;
  localparam logic [M:0] A180  = (M+1)'(ANG_180);
  localparam logic [M:0] AM180 = (M+1)'(ANG_M180);

  logic           accept_c;
  logic [LAT-1:0] dl_v;
  logic [LAT-1:0] dl_neg;
  logic           corr_v;
  logic [N:0]     corr_mag;
  logic [M:0]     corr_ang;
  logic [M:0]     ang_fix_c;
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  fifo_count;
  logic [CW:0]    occ_c;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop_c;
  logic [W-1:0]   head;
  logic [N:0]     hold_mag;
  logic [M:0]     hold_ang;

  // Credits cover everything in the core, the correction stage and the FIFO
  assign occ_c       = {1'b0, inflight} + {1'b0, fifo_count};
  assign issue_ready = ~fifo_full & (occ_c < (CW+1)'(DEPTH));
  assign accept_c    = issue_valid & issue_ready;
  assign m_valid     = ~fifo_empty;
  assign pop_c       = m_valid & m_ready;

  always_comb begin
    ang_fix_c = core_angle;
    if (dl_neg[LAT-1]) ang_fix_c = (core_angle[M] ? AM180 : A180) - core_angle;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_v     <= '0;
      dl_neg   <= '0;
      corr_v   <= 1'b0;
      corr_mag <= '0;
      corr_ang <= '0;
      inflight <= '0;
    end else begin
      dl_v   <= {dl_v[LAT-2:0], accept_c};
      dl_neg <= {dl_neg[LAT-2:0], accept_c & issue_x_neg};
      corr_v <= dl_v[LAT-1];
      if (dl_v[LAT-1]) begin
        corr_mag <= core_xf;
        corr_ang <= ang_fix_c;
      end
      case ({accept_c, corr_v})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: ;
      endcase
    end
  end

  // Last popped entry is shown while the FIFO is empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_mag <= '0;
      hold_ang <= '0;
    end else if (pop_c) begin
      hold_mag <= head[W-1 -: N+1];
      hold_ang <= head[M:0];
    end
  end

  cordic_res_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (corr_v),
    .wdata ({corr_mag, corr_ang}),
    .pop   (pop_c),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_mag   = fifo_empty ? hold_mag : head[W-1 -: N+1];
  assign m_angle = fifo_empty ? hold_ang : head[M:0];

endmodule

// File: tb/tb_cordic_vec_collect.sv
// Scoreboard bench: a behavioural core model feeds the collector, expected results queue at issue.
module tb_cordic_vec_collect;
  import cordic_pkg::*;

  localparam int unsigned LAT   = LAT_DEF;
  localparam int unsigned DEPTH = DEPTH_DEF;
  localparam longint      DEG   = 1048576;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_x_neg = 1'b0;
  logic        m_ready = 1'b0;
  logic        issue_ready;
  logic        m_valid;
  logic [31:0] core_xf = '0;
  logic [31:0] core_angle = '0;
  logic [31:0] m_mag;
  logic [31:0] m_angle;

  typedef struct {
    cordic_res_t res;
    int          rdy;
  } exp_t;

  exp_t        sb[$];
  cordic_res_t force_q[$];
  cordic_res_t pend[int];
  cordic_res_t last_out = '0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          accepts = 0;

  cordic_vec_collect u_dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_x_neg (issue_x_neg),
    .issue_ready (issue_ready),
    .core_xf     (core_xf),
    .core_angle  (core_angle),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_mag       (m_mag),
    .m_angle     (m_angle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Left-half-plane fold in plain degree arithmetic
  function automatic logic [31:0] ref_angle(input logic [31:0] th, input logic neg);
    longint t;
    longint r;
    t = longint'($signed(th));
    if (!neg)        r = t;
    else if (t >= 0) r = 180 * DEG - t;
    else             r = -180 * DEG - t;
    return r[31:0];
  endfunction

  // Core model: result appears in the cycle before the capturing edge, garbage otherwise
  always @(posedge clk) begin
    #1;
    if (pend.exists(cyc)) begin
      core_xf    = pend[cyc].mag;
      core_angle = pend[cyc].angle;
      pend.delete(cyc);
    end else begin
      core_xf    = $urandom;
      core_angle = $urandom;
    end
  end

  cordic_res_t in_core;
  exp_t        in_ent;
  int          rand_ang;

  // Issue side: every accepted sample gets core data and an expected result
  always @(negedge clk) begin
    #1;
    if (rst && issue_valid && issue_ready) begin
      if (force_q.size() > 0) begin
        in_core = force_q.pop_front();
      end else begin
        rand_ang      = int'($urandom_range(0, 188743680)) - 94371840;
        in_core.mag   = $urandom;
        in_core.angle = 32'(rand_ang);
      end
      pend[cyc + int'(LAT)] = in_core;
      in_ent.res.mag   = in_core.mag;
      in_ent.res.angle = ref_angle(in_core.angle, issue_x_neg);
      in_ent.rdy       = cyc + int'(LAT) + 2;
      sb.push_back(in_ent);
      accepts++;
    end
  end

  exp_t out_ent;
  logic exp_valid;

  // Output side: credit and valid expectations, then pop-and-compare
  always @(negedge clk) begin
    if (rst) begin
      check("issue_ready", 32'(issue_ready), 32'(sb.size() < int'(DEPTH)));
      exp_valid = (sb.size() > 0) && (sb[0].rdy <= cyc);
      check("m_valid", 32'(m_valid), 32'(exp_valid));
      if (!m_valid) begin
        check("hold_mag", m_mag, last_out.mag);
        check("hold_angle", m_angle, last_out.angle);
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'(m_valid), 32'd0);
        end else begin
          out_ent = sb.pop_front();
          check("m_mag", m_mag, out_ent.res.mag);
          check("m_angle", m_angle, out_ent.res.angle);
          last_out = out_ent.res;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input logic [31:0] mag, input logic [31:0] ang, input logic neg);
    cordic_res_t f;
    f.mag   = mag;
    f.angle = ang;
    force_q.push_back(f);
    step();
    issue_valid = 1'b1;
    issue_x_neg = neg;
    step();
    issue_valid = 1'b0;
    repeat (LAT + 4) step();
  endtask

  int a0;

  initial begin
    repeat (3) step();
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_mag", m_mag, 32'd0);
    check("rst_m_angle", m_angle, 32'd0);
    rst = 1'b1;
    step();
    check("rst_issue_ready", 32'(issue_ready), 32'd1);

    // Directed corrections and the zero input
    m_ready = 1'b1;
    directed(32'h1234_5678, 32'h0352_2000, 1'b0);
    directed(32'h0765_4321, 32'h0352_2000, 1'b1);
    directed(32'h00AB_CDEF, 32'hFD30_0000, 1'b1);
    directed(32'h0000_1000, 32'h0000_0000, 1'b1);
    directed(32'h0000_0000, 32'h0000_0000, 1'b0);

    // Full-rate stream with random tags
    a0 = accepts;
    issue_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      issue_x_neg = 1'($urandom);
      step();
    end
    issue_valid = 1'b0;
    check("stream_accepts", 32'(accepts - a0), 32'd100);
    repeat (LAT + 5) step();

    // Backpressure: credits stop at DEPTH
    m_ready = 1'b0;
    a0 = accepts;
    issue_valid = 1'b1;
    for (int i = 0; i < 45; i++) begin
      issue_x_neg = 1'($urandom);
      step();
    end
    issue_valid = 1'b0;
    check("bp_accepts", 32'(accepts - a0), 32'(DEPTH));
    repeat (LAT + 3) step();
    check("bp_ready_low", 32'(issue_ready), 32'd0);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("credit_after_pop", 32'(issue_ready), 32'd1);
    m_ready = 1'b1;
    repeat (DEPTH + 5) step();
    check("bp_drained", 32'(sb.size()), 32'd0);

    // Mid-stream reset: 5 in FIFO, 10 in flight
    m_ready = 1'b0;
    issue_valid = 1'b1;
    repeat (5) step();
    issue_valid = 1'b0;
    repeat (LAT + 3) step();
    issue_valid = 1'b1;
    repeat (10) step();
    issue_valid = 1'b0;
    check("pre_rst_valid", 32'(m_valid), 32'd1);
    rst = 1'b0;
    sb.delete();
    pend.delete();
    force_q.delete();
    last_out = '0;
    #1;
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_m_mag", m_mag, 32'd0);
    check("midrst_m_angle", m_angle, 32'd0);
    repeat (2) step();
    rst = 1'b1;
    m_ready = 1'b1;
    check("midrst_ready", 32'(issue_ready), 32'd1);
    repeat (LAT + 2) begin
      step();
      check("no_stale", 32'(m_valid), 32'd0);
    end

    // Random traffic: heavy stall phase keeps the FIFO near full, then 50% ready
    for (int i = 0; i < 800; i++) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_x_neg = 1'($urandom);
      m_ready     = (i < 300) ? ($urandom_range(0, 4) == 0) : 1'($urandom);
      step();
    end
    issue_valid = 1'b0;
    m_ready = 1'b1;
    repeat (DEPTH + LAT + 5) step();
    check("final_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
